// File: rtl/hazard_control_unit.sv
// Hazard controller: load-use stalls, taken-branch flushes and data-memory wait stalls,
// plus saturating hazard counters and a memory-timeout watchdog.
module hazard_control_unit #(
  parameter int COUNT_WIDTH    = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   rstN,
  input  logic [4:0]             rs1Decode,
  input  logic [4:0]             rs2Decode,
  input  logic                   usesRs1Decode,
  input  logic                   usesRs2Decode,
  input  logic                   memReadExecute,
  input  logic [4:0]             rdExecute,
  input  logic                   branchTakenExecute,
  input  logic                   memRequestMemory,
  input  logic                   memReadyMemory,
  output logic                   stallFetch,
  output logic                   stallDecode,
  output logic                   flushDecode,
  output logic                   flushExecute,
  output logic                   stallExecute,
  output logic                   stallMemory,
  output logic                   bubbleWriteBack,
  output logic                   memTimeoutError,
  output logic [COUNT_WIDTH-1:0] loadUseCount,
  output logic [COUNT_WIDTH-1:0] memStallCount,
  output logic [COUNT_WIDTH-1:0] flushCount
);

  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic {ST_RUN, ST_WAIT} state_t;

  state_t            state, next_state;
  logic [WAIT_W-1:0] wait_count, next_wait_count;
  logic              load_use, mem_stall, timeout;
  logic              branch_win, load_use_win;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state      <= ST_RUN;
      wait_count <= '0;
    end else begin
      state      <= next_state;
      wait_count <= next_wait_count;
    end
  end

  // The watchdog fires on the cycle that would be the TIMEOUT_CYCLES-th wait cycle,
  // and that cycle is released so the pipeline can move on.
  always_comb begin
    next_state      = state;
    next_wait_count = wait_count;
    timeout         = 1'b0;
    mem_stall       = 1'b0;
    load_use = memReadExecute && (rdExecute != 5'd0) &&
               ((usesRs1Decode && (rs1Decode == rdExecute)) ||
                (usesRs2Decode && (rs2Decode == rdExecute)));
    case (state)
      ST_RUN: begin
        mem_stall = memRequestMemory && !memReadyMemory;
        if (mem_stall) begin
          next_state      = ST_WAIT;
          next_wait_count = WAIT_W'(1);
        end
      end
      ST_WAIT: begin
        if (memReadyMemory) begin
          next_state      = ST_RUN;
          next_wait_count = '0;
        end else if (wait_count == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
          timeout         = 1'b1;
          next_state      = ST_RUN;
          next_wait_count = '0;
        end else begin
          mem_stall       = 1'b1;
          next_wait_count = wait_count + 1'b1;
        end
      end
      default: begin
        next_state      = ST_RUN;
        next_wait_count = '0;
      end
    endcase
  end

  always_comb begin
    stallFetch      = 1'b0;
    stallDecode     = 1'b0;
    flushDecode     = 1'b0;
    flushExecute    = 1'b0;
    stallExecute    = 1'b0;
    stallMemory     = 1'b0;
    bubbleWriteBack = 1'b0;
    branch_win      = 1'b0;
    load_use_win    = 1'b0;
    if (mem_stall) begin
      stallFetch      = 1'b1;
      stallDecode     = 1'b1;
      stallExecute    = 1'b1;
      stallMemory     = 1'b1;
      bubbleWriteBack = 1'b1;
    end else if (branchTakenExecute) begin
      branch_win   = 1'b1;
      flushDecode  = 1'b1;
      flushExecute = 1'b1;
    end else if (load_use) begin
      load_use_win = 1'b1;
      stallFetch   = 1'b1;
      stallDecode  = 1'b1;
      flushExecute = 1'b1;
    end
  end

  // Counters saturate at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      memTimeoutError <= 1'b0;
      loadUseCount    <= '0;
      memStallCount   <= '0;
      flushCount      <= '0;
    end else begin
      if (timeout)
        memTimeoutError <= 1'b1;
      if (load_use_win && (loadUseCount != '1))
        loadUseCount <= loadUseCount + 1'b1;
      if (mem_stall && (memStallCount != '1))
        memStallCount <= memStallCount + 1'b1;
      if (branch_win && (flushCount != '1))
        flushCount <= flushCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Randomized and directed bench for hazard_control_unit against a cycle-level
// reference model of the hazard rules.
module tb_hazard_control_unit;

  localparam int CW      = 4;
  localparam int TO      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rstN;
  logic [4:0]    rs1Decode, rs2Decode, rdExecute;
  logic          usesRs1Decode, usesRs2Decode, memReadExecute;
  logic          branchTakenExecute, memRequestMemory, memReadyMemory;
  logic          stallFetch, stallDecode, flushDecode, flushExecute;
  logic          stallExecute, stallMemory, bubbleWriteBack, memTimeoutError;
  logic [CW-1:0] loadUseCount, memStallCount, flushCount;

  int checks = 0;
  int errors = 0;

  bit mInWait;
  int mWaited;
  bit mErr;
  int mLoadUse, mMemStall, mFlush;

  always #5 clk = ~clk;

  hazard_control_unit #(.COUNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rstN(rstN),
    .rs1Decode(rs1Decode), .rs2Decode(rs2Decode),
    .usesRs1Decode(usesRs1Decode), .usesRs2Decode(usesRs2Decode),
    .memReadExecute(memReadExecute), .rdExecute(rdExecute),
    .branchTakenExecute(branchTakenExecute),
    .memRequestMemory(memRequestMemory), .memReadyMemory(memReadyMemory),
    .stallFetch(stallFetch), .stallDecode(stallDecode),
    .flushDecode(flushDecode), .flushExecute(flushExecute),
    .stallExecute(stallExecute), .stallMemory(stallMemory),
    .bubbleWriteBack(bubbleWriteBack), .memTimeoutError(memTimeoutError),
    .loadUseCount(loadUseCount), .memStallCount(memStallCount),
    .flushCount(flushCount)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  task automatic checkRegs(input string tag);
    checkOutput({tag, ".err"},     32'(memTimeoutError), 32'(mErr));
    checkOutput({tag, ".luCnt"},   32'(loadUseCount),    32'(mLoadUse));
    checkOutput({tag, ".msCnt"},   32'(memStallCount),   32'(mMemStall));
    checkOutput({tag, ".flCnt"},   32'(flushCount),      32'(mFlush));
  endtask

  // Called at posedge+1: drives one cycle, checks controls mid-cycle, counters after the edge.
  task automatic applyStimulus(input string tag, input logic [4:0] r1, input logic [4:0] r2,
                               input logic u1, input logic u2, input logic mr,
                               input logic [4:0] rd, input logic br,
                               input logic req, input logic rdy);
    bit hazard, memStallNow, lastChance;
    logic [6:0] expCtl;
    rs1Decode = r1; rs2Decode = r2; usesRs1Decode = u1; usesRs2Decode = u2;
    memReadExecute = mr; rdExecute = rd; branchTakenExecute = br;
    memRequestMemory = req; memReadyMemory = rdy;
    #3;
    hazard = mr && (rd != 0) && ((u1 && r1 == rd) || (u2 && r2 == rd));
    lastChance = mInWait && !rdy && (mWaited + 1 == TO);
    memStallNow = mInWait ? (!rdy && !lastChance) : (req && !rdy);
    // {stallFetch, stallDecode, flushDecode, flushExecute, stallExecute, stallMemory, bubble}
    if (memStallNow)  expCtl = 7'b1100111;
    else if (br)      expCtl = 7'b0011000;
    else if (hazard)  expCtl = 7'b1101000;
    else              expCtl = 7'b0000000;
    checkOutput({tag, ".ctl"}, 32'({stallFetch, stallDecode, flushDecode, flushExecute,
                                    stallExecute, stallMemory, bubbleWriteBack}), 32'(expCtl));
    @(posedge clk);
    #1;
    if (memStallNow) mMemStall = sat(mMemStall);
    else if (br)     mFlush    = sat(mFlush);
    else if (hazard) mLoadUse  = sat(mLoadUse);
    if (!mInWait) begin
      if (req && !rdy) begin mInWait = 1; mWaited = 1; end
    end else if (rdy) begin
      mInWait = 0; mWaited = 0;
    end else if (lastChance) begin
      mErr = 1; mInWait = 0; mWaited = 0;
    end else begin
      mWaited++;
    end
    checkRegs(tag);
  endtask

  task automatic idle(input string tag);
    applyStimulus(tag, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0);
  endtask

  task automatic doReset(input string tag);
    rs1Decode = 0; rs2Decode = 0; usesRs1Decode = 0; usesRs2Decode = 0;
    memReadExecute = 0; rdExecute = 0; branchTakenExecute = 0;
    memRequestMemory = 0; memReadyMemory = 0;
    rstN = 1'b0;
    #2;
    mInWait = 0; mWaited = 0; mErr = 0; mLoadUse = 0; mMemStall = 0; mFlush = 0;
    checkOutput({tag, ".ctl"}, 32'({stallFetch, stallDecode, flushDecode, flushExecute,
                                    stallExecute, stallMemory, bubbleWriteBack}), 32'd0);
    checkRegs(tag);
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstN = 1'b0;
    @(posedge clk);
    #1;
    doReset("reset");

    // Load-use on rs2, then a load to x0 that must not stall.
    applyStimulus("loaduse", 5'd1, 5'd5, 0, 1, 1, 5'd5, 0, 0, 0);
    checkOutput("loaduse.count1", 32'(loadUseCount), 32'd1);
    idle("loaduse.after");
    applyStimulus("loadx0", 5'd0, 5'd3, 1, 0, 1, 5'd0, 0, 0, 0);
    checkOutput("loadx0.count", 32'(loadUseCount), 32'd1);

    // Branch beats a concurrent load-use.
    doReset("reset2");
    applyStimulus("brlu", 5'd7, 5'd2, 1, 0, 1, 5'd7, 1, 0, 0);
    checkOutput("brlu.flush", 32'(flushCount), 32'd1);
    checkOutput("brlu.lu", 32'(loadUseCount), 32'd0);

    // Memory wait of three cycles with a branch held across it.
    doReset("reset3");
    for (int i = 0; i < 3; i++)
      applyStimulus("memwait", 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 1, 0);
    applyStimulus("memrdy", 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 1, 1);
    checkOutput("memwait.count", 32'(memStallCount), 32'd3);
    idle("memwait.after");

    // Watchdog: the 4th wait cycle is released and the sticky flag sets.
    for (int i = 0; i < 4; i++)
      applyStimulus("wdog", 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0);
    checkOutput("wdog.flag", 32'(memTimeoutError), 32'd1);
    applyStimulus("wdog.rewait", 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0);
    applyStimulus("wdog.rdy", 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 1);
    checkOutput("wdog.sticky", 32'(memTimeoutError), 32'd1);

    // Reset in the middle of a wait abandons it.
    applyStimulus("midwait", 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0);
    applyStimulus("midwait", 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0);
    doReset("midreset");
    idle("midreset.after");

    // Saturation after 20 load-use cycles.
    for (int i = 0; i < 20; i++)
      applyStimulus("sat", 5'd9, 5'd0, 1, 0, 1, 5'd9, 0, 0, 0);
    checkOutput("sat.count", 32'(loadUseCount), 32'd15);

    // Randomized traffic over a small register window to provoke matches.
    doReset("reset4");
    for (int i = 0; i < 600; i++) begin
      applyStimulus("rand",
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                    1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 2) == 0),
                    1'($urandom_range(0, 1)));
      if (i == 300) doReset("rand.reset");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
